reg_arb: RTL and testbench

Shared 16 x 8 register bank sitting between the SPI slave memory port and the local counter core. The SPI side is never stalled: its reads are combinational and its writes commit on the strobe cycle. The core side reaches the bank through a req/ack handshake, and the block arbitrates between the two. It also holds off core writes to frame-locked registers while an SPI frame is active, and reports which registers the SPI master changed once the frame ends.

---
 rtl/reg_arb.sv | 121 ++++++++++++
 tb/tb_reg_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_arb.sv
// Shared 16x8 register bank: the SPI port reads combinationally and writes at once;
// the core port goes through a req/ack FSM that yields to SPI writes and frame locks.
module reg_arb #(
  parameter logic [15:0] RO_MASK   = 16'h0000,
  parameter logic [15:0] LOCK_MASK = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   spi_addr,
  input  logic [7:0]   spi_wdata,
  input  logic         spi_wrt,
  output logic [7:0]   spi_rdata,
  input  logic         spi_busy,
  input  logic         core_req,
  input  logic         core_wen,
  input  logic [3:0]   core_addr,
  input  logic [7:0]   core_wdata,
  output logic         core_ack,
  output logic [7:0]   core_rdata,
  output logic [127:0] reg_q,
  output logic         upd,
  output logic [15:0]  upd_mask
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [7:0]  bank [16];
  logic [1:0]  state;
  logic        c_wen;
  logic [3:0]  c_addr;
  logic [7:0]  c_wdata;
  logic        busy_q;
  logic [15:0] dirty;

  logic        spi_we;
  logic        core_blocked;
  logic        core_we;
  logic        core_rd;
  logic        busy_fall;
  logic [15:0] dirty_next;

  // NOTE: every signal gets a value at the top of always_comb so no path can infer a latch.
  always_comb begin
    spi_we       = spi_wrt && !RO_MASK[spi_addr];
    core_blocked = spi_wrt || (c_wen && spi_busy && LOCK_MASK[c_addr]);
    core_we      = (state == WAIT) && c_wen && !core_blocked;
    core_rd      = (state == WAIT) && !c_wen && !core_blocked;
    busy_fall    = busy_q && !spi_busy;
    dirty_next   = dirty;
    if (spi_we) dirty_next[spi_addr] = 1'b1;
  end

  assign spi_rdata = bank[spi_addr];
  assign core_ack  = (state == DONE);

  for (genvar i = 0; i < 16; i++) begin : g_flat
    assign reg_q[8*i +: 8] = bank[i];
  end

  // NOTE: the bank must come up as zero, so every entry is cleared on reset; this keeps it in flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
    end else if (spi_we) begin
      bank[spi_addr] <= spi_wdata;
    end else if (core_we) begin
      bank[c_addr] <= c_wdata;
    end
  end

  // NOTE: state is updated with <= so every block samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      c_wen      <= 1'b0;
      c_addr     <= '0;
      c_wdata    <= '0;
      core_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (core_req) begin
          c_wen   <= core_wen;
          c_addr  <= core_addr;
          c_wdata <= core_wdata;
          state   <= WAIT;
        end
        WAIT: begin
          if (core_rd) core_rdata <= bank[c_addr];
          if (core_we || core_rd) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A write landing in the same cycle as the end of frame still counts for that frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      dirty    <= '0;
      upd      <= 1'b0;
      upd_mask <= '0;
    end else begin
      busy_q <= spi_busy;
      upd    <= 1'b0;
      if (busy_fall) begin
        dirty <= '0;
        if (dirty_next != '0) begin
          upd      <= 1'b1;
          upd_mask <= dirty_next;
        end
      end else begin
        dirty <= dirty_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_arb.sv
// Directed bench for reg_arb: stimulus pushes expected core/upd responses into queues,
// an independent monitor pops and compares whenever core_ack or upd is seen.
module tb_reg_arb;

  logic         clk;
  logic         rst;
  logic [3:0]   spi_addr;
  logic [7:0]   spi_wdata;
  logic         spi_wrt;
  logic [7:0]   spi_rdata;
  logic         spi_busy;
  logic         core_req;
  logic         core_wen;
  logic [3:0]   core_addr;
  logic [7:0]   core_wdata;
  logic         core_ack;
  logic [7:0]   core_rdata;
  logic [127:0] reg_q;
  logic         upd;
  logic [15:0]  upd_mask;

  reg_arb #(.RO_MASK(16'h8000), .LOCK_MASK(16'h0001)) dut (
    .clk(clk), .rst(rst),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_wrt(spi_wrt),
    .spi_rdata(spi_rdata), .spi_busy(spi_busy),
    .core_req(core_req), .core_wen(core_wen), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
    .reg_q(reg_q), .upd(upd), .upd_mask(upd_mask)
  );

  typedef struct {
    logic       wen;
    logic [7:0] rdata;
    int         lat;
    int         issue;
    string      name;
  } core_exp_t;

  core_exp_t   core_q[$];
  logic [15:0] upd_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int upd_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: latency is measured from the cycle the request was driven to the cycle ack is seen.
  always @(negedge clk) begin
    core_exp_t e;
    logic [15:0] m;
    if (rst) begin
      if (core_ack) begin
        if (core_q.size() == 0) check("ack_spurious", 1, 0);
        else begin
          e = core_q.pop_front();
          check({e.name, "_lat"}, cyc - e.issue, e.lat);
          if (!e.wen) check({e.name, "_rdata"}, core_rdata, e.rdata);
        end
      end
      if (upd) begin
        upd_seen++;
        if (upd_q.size() == 0) check("upd_spurious", 1, 0);
        else begin
          m = upd_q.pop_front();
          check("upd_mask", upd_mask, m);
        end
      end
    end
  end

  task automatic core_op(input logic wen, input logic [3:0] addr, input logic [7:0] wdata,
                         input logic [7:0] exp_rdata, input int exp_lat, input string name);
    core_exp_t e;
    bit got;
    e.wen = wen; e.rdata = exp_rdata; e.lat = exp_lat; e.issue = cyc; e.name = name;
    core_q.push_back(e);
    core_req = 1'b1; core_wen = wen; core_addr = addr; core_wdata = wdata;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = core_ack;
    end
    if (!got) check({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
    core_req = 1'b0;
  endtask

  // Single-cycle SPI strobe starting in the next cycle.
  task automatic spi_pulse_next(input logic [3:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    spi_wrt = 1'b1; spi_addr = addr; spi_wdata = data;
    @(posedge clk); #1;
    spi_wrt = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; spi_addr = '0; spi_wdata = '0; spi_wrt = 1'b0; spi_busy = 1'b0;
    core_req = 1'b1; core_wen = 1'b1; core_addr = 4'd3; core_wdata = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", core_ack, 0);
    check("rst_reg_q", reg_q, 0);
    check("rst_upd", upd, 0);
    check("rst_upd_mask", upd_mask, 0);
    check("rst_rdata", core_rdata, 0);
    @(posedge clk); #1;
    core_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;

    core_op(1'b1, 4'd3, 8'hA5, 8'h00, 2, "wr3");
    check("wr3_bank", reg_q[31:24], 8'hA5);
    core_op(1'b0, 4'd3, 8'h00, 8'hA5, 2, "rd3");

    // Frame 1: collision tests; SPI writes to 5 and 2 make them dirty.
    spi_busy = 1'b1;
    fork
      core_op(1'b1, 4'd5, 8'h11, 8'h00, 3, "wr5_col");
      begin
        spi_pulse_next(4'd5, 8'h22);
        @(negedge clk);
        check("spi5_first", reg_q[47:40], 8'h22);
      end
    join
    check("wr5_final", reg_q[47:40], 8'h11);
    check("spi_rdata5", spi_rdata, 8'h11);

    repeat (16) @(posedge clk);
    #1;
    fork
      core_op(1'b0, 4'd2, 8'h00, 8'h3C, 3, "rd2_stall");
      spi_pulse_next(4'd2, 8'h3C);
    join

    upd_q.push_back(16'h0024);
    spi_busy = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("upd1_one_cycle", upd, 0);
    check("upd1_mask_held", upd_mask, 16'h0024);

    // Frame 2: lock window on register 0; register 1 is not locked.
    @(posedge clk); #1;
    spi_busy = 1'b1;
    fork
      begin
        core_op(1'b1, 4'd1, 8'h5A, 8'h00, 2, "wr1_lockwin");
        // Issued 3 cycles into the frame; busy low from cycle 40, commit there, ack next cycle.
        core_op(1'b1, 4'd0, 8'h7E, 8'h00, 38, "wr0_locked");
      end
      begin
        repeat (39) @(posedge clk);
        @(negedge clk);
        check("lock_hold_bank0", reg_q[7:0], 8'h00);
        check("lock_hold_ack", core_ack, 0);
        @(posedge clk); #1;
        spi_busy = 1'b0;
      end
    join
    check("wr0_bank", reg_q[7:0], 8'h7E);
    check("wr1_bank", reg_q[15:8], 8'h5A);

    // Frame 3: read-only register 15, dirty 4 and 9 (9 written in the falling-edge cycle).
    spi_busy = 1'b1;
    spi_pulse_next(4'd15, 8'hFF);
    @(negedge clk);
    check("ro15_spi_rdata", spi_rdata, 8'h00);
    repeat (16) @(posedge clk);
    #1;
    spi_wrt = 1'b1; spi_addr = 4'd4; spi_wdata = 8'h44;
    @(posedge clk); #1;
    spi_wrt = 1'b0;
    @(negedge clk);
    check("spi4_rdata", spi_rdata, 8'h44);
    repeat (16) @(posedge clk);
    #1;
    upd_q.push_back(16'h0210);
    spi_wrt = 1'b1; spi_addr = 4'd9; spi_wdata = 8'h99; spi_busy = 1'b0;
    @(posedge clk); #1;
    spi_wrt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("upd3_one_cycle", upd, 0);
    check("upd3_mask_held", upd_mask, 16'h0210);
    check("spi9_bank", reg_q[79:72], 8'h99);
    check("ro15_bank", reg_q[127:120], 8'h00);

    // Frame 4: empty frame must not pulse upd.
    @(posedge clk); #1;
    spi_busy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    spi_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("empty_mask_held", upd_mask, 16'h0210);
    check("upd_pulse_count", upd_seen, 2);

    // Reset in the middle of a core write aborts it.
    @(posedge clk); #1;
    core_req = 1'b1; core_wen = 1'b1; core_addr = 4'd6; core_wdata = 8'h66;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ack", core_ack, 0);
    check("midrst_reg_q", reg_q, 0);
    check("midrst_upd_mask", upd_mask, 0);
    check("midrst_rdata", core_rdata, 0);
    @(posedge clk); #1;
    core_req = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("postrst_ack", core_ack, 0);
    check("postrst_reg_q", reg_q, 0);
    @(posedge clk); #1;
    core_op(1'b0, 4'd6, 8'h00, 8'h00, 2, "rd6_postrst");

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("core_q_drained", core_q.size(), 0);
    check("upd_q_drained", upd_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
